// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the MIPS datapath: walks each instruction through
// IF/ID/EXE/MEM/WB, gates every write enable per state and counts retired instructions.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        PCwrt,
    output logic        IRwrt,
    output logic        jump,
    output logic        branch,
    output logic        regWrt,
    output logic        regDst,
    output logic        memToReg,
    output logic        memRd,
    output logic        memWrt,
    output logic        ALUsrcA,
    output logic        ALUsrcB,
    output logic        extOp,
    output logic [2:0]  ALUctr,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    state_t      state_reg, state_next;
    logic        halted_reg;
    logic [31:0] instr_cnt_reg;

    logic is_r, is_lw, is_sw, is_beq, is_bne, is_bltz, is_j, is_halt, is_illegal;
    logic is_andi, is_ori;
    logic is_branch;
    logic dec_src_a, dec_src_b, dec_ext, dec_dst, dec_mem2reg;
    logic [2:0] dec_ctr;
    logic dec_active;
    logic pc_next, ir_next, jump_next, branch_next, reg_next, rd_next, wr_next;

    // Instruction classification and ALU decode, purely from op/funct.
    always_comb begin
        is_r       = 1'b0;
        is_illegal = 1'b0;
        dec_ctr    = ALU_ADD;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        case (op)
            OP_RTYPE: begin
                is_r = 1'b1;
                case (funct)
                    6'b100000: dec_ctr = ALU_ADD;
                    6'b100010: dec_ctr = ALU_SUB;
                    6'b100100: dec_ctr = ALU_AND;
                    6'b100101: dec_ctr = ALU_OR;
                    6'b000000: begin
                        dec_ctr   = ALU_SLL;
                        dec_src_a = 1'b1;
                    end
                    default: begin
                        is_r       = 1'b0;
                        is_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: dec_src_b = 1'b1;
            OP_ANDI: begin
                dec_src_b = 1'b1;
                dec_ctr   = ALU_AND;
            end
            OP_ORI: begin
                dec_src_b = 1'b1;
                dec_ctr   = ALU_OR;
            end
            OP_SLTI: begin
                dec_src_b = 1'b1;
                dec_ctr   = ALU_SLT;
            end
            OP_LW, OP_SW: dec_src_b = 1'b1;
            OP_BEQ, OP_BNE: dec_ctr = ALU_SUB;
            OP_BLTZ: dec_ctr = ALU_SLT;
            OP_J, OP_HALT: dec_ctr = ALU_ADD;
            default: is_illegal = 1'b1;
        endcase
    end

    assign is_lw       = (op == OP_LW);
    assign is_sw       = (op == OP_SW);
    assign is_beq      = (op == OP_BEQ);
    assign is_bne      = (op == OP_BNE);
    assign is_bltz     = (op == OP_BLTZ);
    assign is_j        = (op == OP_J);
    assign is_halt     = (op == OP_HALT);
    assign is_andi     = (op == OP_ANDI);
    assign is_ori      = (op == OP_ORI);
    assign is_branch   = is_beq | is_bne | is_bltz;
    assign dec_ext     = ~(is_andi | is_ori);
    assign dec_dst     = is_r;
    assign dec_mem2reg = is_lw;

    // Next state and per-state enables; PC is written only in an instruction's last cycle.
    always_comb begin
        state_next  = state_reg;
        pc_next     = 1'b0;
        ir_next     = 1'b0;
        jump_next   = 1'b0;
        branch_next = 1'b0;
        reg_next    = 1'b0;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        case (state_reg)
            S_IF: begin
                ir_next    = 1'b1;
                state_next = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    jump_next  = 1'b1;
                    pc_next    = 1'b1;
                    state_next = S_IF;
                end else if (is_illegal) begin
                    pc_next    = 1'b1;
                    state_next = S_IF;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXE;
                end
            end
            S_EXE: begin
                if (is_branch) begin
                    pc_next     = 1'b1;
                    branch_next = (is_beq & zero) | ((is_bne | is_bltz) & ~zero);
                    state_next  = S_IF;
                end else if (is_lw | is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    rd_next    = 1'b1;
                    state_next = S_WB;
                end else begin
                    wr_next    = is_sw;
                    pc_next    = 1'b1;
                    state_next = S_IF;
                end
            end
            S_WB: begin
                reg_next   = 1'b1;
                rd_next    = is_lw;
                pc_next    = 1'b1;
                state_next = S_IF;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    assign PCwrt  = pc_next & ~reset;
    assign IRwrt  = ir_next & ~reset;
    assign jump   = jump_next & ~reset;
    assign branch = branch_next & ~reset;
    assign regWrt = reg_next & ~reset;
    assign memRd  = rd_next & ~reset;
    assign memWrt = wr_next & ~reset;

    assign dec_active = (state_reg == S_ID) | (state_reg == S_EXE) |
                        (state_reg == S_MEM) | (state_reg == S_WB);
    assign ALUsrcA  = dec_active & dec_src_a;
    assign ALUsrcB  = dec_active & dec_src_b;
    assign extOp    = dec_active & dec_ext;
    assign regDst   = dec_active & dec_dst;
    assign memToReg = dec_active & dec_mem2reg;
    assign ALUctr   = dec_active ? dec_ctr : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IF;
            halted_reg    <= 1'b0;
            instr_cnt_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == S_HALT);
            if (PCwrt)
                instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    assign state     = state_reg;
    assign halted    = halted_reg;
    assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: an instruction-level model
// schedules the expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero;
    logic        PCwrt, IRwrt, jump, branch, regWrt, regDst, memToReg;
    logic        memRd, memWrt, ALUsrcA, ALUsrcB, extOp, halted;
    logic [2:0]  ALUctr, state;
    logic [31:0] instr_cnt;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCwrt(PCwrt), .IRwrt(IRwrt), .jump(jump), .branch(branch),
        .regWrt(regWrt), .regDst(regDst), .memToReg(memToReg),
        .memRd(memRd), .memWrt(memWrt), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .extOp(extOp), .ALUctr(ALUctr), .state(state), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_SLL, K_ADDIU, K_ANDI, K_ORI, K_SLTI,
        K_LW, K_SW, K_BEQ, K_BNE, K_BLTZ, K_J, K_ILLOP, K_ILLFN, K_HALT
    } kind_e;

    typedef struct {
        logic [2:0]  st;
        logic        hlt;
        logic [6:0]  en;   // {PCwrt, IRwrt, jump, branch, regWrt, memRd, memWrt}
        logic [7:0]  dec;  // {ALUsrcA, ALUsrcB, extOp, regDst, memToReg, ALUctr}
        logic [31:0] cnt;
        bit          chk_dec;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    function automatic logic [5:0] kind_op(kind_e k);
        case (k)
            K_ADDIU: return 6'b001001;
            K_ANDI:  return 6'b001100;
            K_ORI:   return 6'b001101;
            K_SLTI:  return 6'b001010;
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_BEQ:   return 6'b000100;
            K_BNE:   return 6'b000101;
            K_BLTZ:  return 6'b000001;
            K_J:     return 6'b000010;
            K_ILLOP: return 6'b110011;
            K_HALT:  return 6'b111111;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] kind_funct(kind_e k);
        case (k)
            K_ADD:   return 6'b100000;
            K_SUB:   return 6'b100010;
            K_AND:   return 6'b100100;
            K_OR:    return 6'b100101;
            K_SLL:   return 6'b000000;
            K_ILLFN: return 6'b111001;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic int kind_cycles(kind_e k);
        case (k)
            K_J, K_ILLOP, K_ILLFN, K_HALT: return 2;
            K_BEQ, K_BNE, K_BLTZ:          return 3;
            K_LW:                          return 5;
            default:                       return 4;
        endcase
    endfunction

    function automatic logic [7:0] kind_dec(kind_e k);
        logic [2:0] ctr;
        logic a, b, e, d, m;
        case (k)
            K_SUB, K_BEQ, K_BNE: ctr = 3'b001;
            K_SLL:               ctr = 3'b010;
            K_OR, K_ORI:         ctr = 3'b011;
            K_AND, K_ANDI:       ctr = 3'b100;
            K_SLTI, K_BLTZ:      ctr = 3'b110;
            default:             ctr = 3'b000;
        endcase
        a = (k == K_SLL);
        b = (k inside {K_ADDIU, K_ANDI, K_ORI, K_SLTI, K_LW, K_SW});
        e = !(k inside {K_ANDI, K_ORI});
        d = (k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLL});
        m = (k == K_LW);
        return {a, b, e, d, m, ctr};
    endfunction

    task automatic push_step(input exp_t r);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; rst_at >= 0 asserts reset during that cycle of it.
    task automatic run_instr(input kind_e k, input logic z, input int rst_at);
        int   n;
        bit   last;
        bit   taken;
        exp_t r;
        n     = kind_cycles(k);
        op    = kind_op(k);
        funct = kind_funct(k);
        zero  = z;
        taken = (k == K_BEQ) ? z : ((k == K_BNE || k == K_BLTZ) ? !z : 1'b0);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            r.st  = (i == 0) ? 3'b000 : (i == 1) ? 3'b001 : (i == 2) ? 3'b010 :
                    (i == 3 && (k == K_LW || k == K_SW)) ? 3'b011 : 3'b100;
            r.hlt = 1'b0;
            r.cnt = exp_cnt;
            r.dec = (i == 0) ? 8'h00 : kind_dec(k);
            r.chk_dec = 1'b1;
            r.en[6] = last && (k != K_HALT);
            r.en[5] = (i == 0);
            r.en[4] = last && (k == K_J);
            r.en[3] = last && taken;
            r.en[2] = last && (n == 4 || n == 5) && (k != K_SW);
            r.en[1] = (k == K_LW) && (i >= 3);
            r.en[0] = last && (k == K_SW);
            if (i == rst_at) begin
                reset     = 1'b1;
                r.en      = 7'd0;
                r.chk_dec = 1'b0;
                push_step(r);
                reset   = 1'b0;
                exp_cnt = 0;
                return;
            end
            push_step(r);
        end
        if (k != K_HALT)
            exp_cnt = exp_cnt + 1;
    endtask

    // Monitor: compares whatever the scoreboard expects for this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] en_act;
        logic [7:0] dec_act;
        if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            en_act  = {PCwrt, IRwrt, jump, branch, regWrt, memRd, memWrt};
            dec_act = {ALUsrcA, ALUsrcB, extOp, regDst, memToReg, ALUctr};
            checks += 4;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state: got %b expected %b (t=%0t)", state, e.st, $time);
            end
            if (halted !== e.hlt) begin
                errors++;
                $display("FAIL halted: got %b expected %b (t=%0t)", halted, e.hlt, $time);
            end
            if (en_act !== e.en) begin
                errors++;
                $display("FAIL enables: got %b expected %b (state %b, t=%0t)", en_act, e.en, e.st, $time);
            end
            if (instr_cnt !== e.cnt) begin
                errors++;
                $display("FAIL instr_cnt: got %0d expected %0d (t=%0t)", instr_cnt, e.cnt, $time);
            end
            if (e.chk_dec) begin
                checks++;
                if (dec_act !== e.dec) begin
                    errors++;
                    $display("FAIL decode: got %b expected %b (op %b funct %b state %b, t=%0t)",
                             dec_act, e.dec, op, funct, e.st, $time);
                end
            end
        end
    end

    initial begin
        exp_t r;
        kind_e k;
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        r.st = 3'b000; r.hlt = 1'b0; r.en = 7'd0; r.dec = 8'h00; r.cnt = 0; r.chk_dec = 1'b1;
        push_step(r);
        reset = 1'b0;

        run_instr(K_ADD, 1'b0, -1);
        run_instr(K_LW, 1'b0, -1);
        run_instr(K_SW, 1'b1, -1);
        run_instr(K_BEQ, 1'b1, -1);
        run_instr(K_BNE, 1'b1, -1);
        run_instr(K_BLTZ, 1'b0, -1);
        run_instr(K_J, 1'b0, -1);
        run_instr(K_ILLOP, 1'b0, -1);
        run_instr(K_ILLFN, 1'b1, -1);

        for (int n = 0; n < 300; n++) begin
            k = kind_e'($urandom_range(0, int'(K_ILLFN)));
            run_instr(k, 1'($urandom), -1);
        end

        run_instr(K_HALT, 1'b0, -1);
        for (int i = 0; i < 20; i++) begin
            op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            r.st = 3'b101; r.hlt = 1'b1; r.en = 7'd0; r.dec = 8'h00; r.cnt = exp_cnt; r.chk_dec = 1'b1;
            push_step(r);
        end
        reset = 1'b1;
        r.st = 3'b101; r.hlt = 1'b1; r.en = 7'd0; r.cnt = exp_cnt; r.chk_dec = 1'b0;
        push_step(r);
        reset   = 1'b0;
        exp_cnt = 0;
        run_instr(K_ADD, 1'b0, -1);

        run_instr(K_LW, 1'b0, 3);
        run_instr(K_SW, 1'b0, -1);
        for (int n = 0; n < 40; n++) begin
            k = kind_e'($urandom_range(0, int'(K_ILLFN)));
            run_instr(k, 1'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
